// File: rtl/axis_packetizer.sv
// AXI4-Stream packetizer: frames a sample stream into tlast-delimited packets.
// Define AXIS_PACKETIZER_STS_EN to add the sts_data completed-packet counter.
module axis_packetizer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [CNTR_WIDTH-1:0]       cfg_data,
    input  logic                        cfg_enable,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast
`ifdef AXIS_PACKETIZER_STS_EN
    ,
    output logic [31:0]                 sts_data
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNTR_WIDTH-1:0] len;
    logic [CNTR_WIDTH-1:0] cnt;
    logic [CNTR_WIDTH-1:0] len_m1;
    logic                  out_free;
    logic                  accept;
    logic                  last_beat;
    logic                  cfg_ok;
    logic                  start;
    logic                  first_start;

    assign out_free = ~m_axis_tvalid | m_axis_tready;
    assign len_m1   = len - CNTR_WIDTH'(1);
    assign cfg_ok   = cfg_enable & (cfg_data != '0);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cfg_ok) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_beat) begin
                    if (!cfg_enable) begin
                        state_next = DRAIN;
                    end else if (cfg_data == '0) begin
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (out_free) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = (state == RUN) & out_free;
        accept        = s_axis_tvalid & s_axis_tready;
        last_beat     = accept & (cnt == len_m1);
        first_start   = (state == IDLE) & cfg_ok;
        // back-to-back packets re-latch the length on the tlast beat
        start         = first_start | (last_beat & cfg_ok);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            len           <= '0;
            cnt           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (start) begin
                len <= cfg_data;
            end
            if (first_start) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= last_beat ? '0 : cnt + CNTR_WIDTH'(1);
            end
            if (out_free) begin
                m_axis_tvalid <= accept;
                m_axis_tlast  <= last_beat;
                if (accept) begin
                    m_axis_tdata <= s_axis_tdata;
                end
            end
        end
    end

`ifdef AXIS_PACKETIZER_STS_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            sts_data <= '0;
        end else if (m_axis_tvalid & m_axis_tready & m_axis_tlast) begin
            sts_data <= sts_data + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_packetizer.sv
// Scoreboard bench for axis_packetizer: directed packets, backpressure,
// disable, boundary lengths and mid-packet reset.
`timescale 1ns/1ps
module tb_axis_packetizer;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic [CW-1:0] cfg_data = '0;
    logic          cfg_enable = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
`ifdef AXIS_PACKETIZER_STS_EN
    logic [31:0]   sts_data;
    logic [31:0]   exp_sts = '0;
`endif

    int            chk = 0;
    int            err = 0;
    int            cyc = 0;
    int            acc_cyc = -1;
    int            first_acc = -1;
    int            val_cyc = -2;
    logic          lat_arm = 1'b0;
    logic          bp = 1'b0;
    logic [DW:0]   exp_q[$];

    axis_packetizer #(
        .AXIS_TDATA_WIDTH(DW),
        .CNTR_WIDTH(CW)
    ) dut (
        .aclk(clk),
        .areset(areset),
        .cfg_data(cfg_data),
        .cfg_enable(cfg_enable),
        .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast)
`ifdef AXIS_PACKETIZER_STS_EN
        ,
        .sts_data(sts_data)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp ? ~m_tready : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic        pst;
        logic [DW:0] pv;
        logic [DW:0] e;
        pst = 1'b0;
        pv  = '0;
        forever begin
            @(negedge clk);
            if (areset) begin
                pst = 1'b0;
`ifdef AXIS_PACKETIZER_STS_EN
                exp_sts = '0;
`endif
                continue;
            end
`ifdef AXIS_PACKETIZER_STS_EN
            check("sts_count", sts_data, exp_sts);
`endif
            if (pst) begin
                check("stall_stable", {m_tvalid, m_tlast, m_tdata}, {1'b1, pv});
            end
            if (lat_arm && m_tvalid) begin
                val_cyc = cyc;
                lat_arm = 1'b0;
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk++;
                    err++;
                    $display("FAIL unexpected_beat: got %0h expected none",
                             {m_tlast, m_tdata});
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {m_tlast, m_tdata}, e);
`ifdef AXIS_PACKETIZER_STS_EN
                    if (e[DW]) exp_sts = exp_sts + 32'd1;
`endif
                end
            end
            pst = m_tvalid && !m_tready;
            pv  = {m_tlast, m_tdata};
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic last,
                        input bit nogap);
        int   n;
        logic ok;
        s_tdata  = d;
        s_tvalid = 1'b1;
        exp_q.push_back({last, d});
        n = 0;
        do begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            chk++;
            err++;
            $display("FAIL accept_timeout: got no accept expected accept of %0h", d);
        end
        if (nogap) check("no_gap", n, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_s_tready", s_tready, 0);
        @(posedge clk);
        #1;
        areset = 1'b0;

        // basic framing, len 4
        cfg_data   = 16'd4;
        cfg_enable = 1'b1;
        lat_arm    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 11) cfg_enable = 1'b0;
            send(DW'(i), (i % 4) == 3, i > 0);
            if (i == 0) first_acc = acc_cyc;
        end
        s_tvalid = 1'b0;
        wait_drain();
        check("latency", val_cyc, first_acc);

        // backpressure, len 3
        bp         = 1'b1;
        cfg_data   = 16'd3;
        cfg_enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) cfg_enable = 1'b0;
            send(DW'(100 + i), (i % 3) == 2, 1'b0);
        end
        s_tvalid = 1'b0;
        wait_drain();
        bp = 1'b0;

        // disable mid-packet, len 5
        cfg_data   = 16'd5;
        cfg_enable = 1'b1;
        send(DW'(200), 1'b0, 1'b0);
        send(DW'(201), 1'b0, 1'b0);
        cfg_enable = 1'b0;
        send(DW'(202), 1'b0, 1'b0);
        send(DW'(203), 1'b0, 1'b0);
        send(DW'(204), 1'b1, 1'b0);
        s_tdata = DW'(299);
        repeat (4) begin
            @(negedge clk);
            check("closed_after_disable", s_tready, 0);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        wait_drain();

        // zero length never opens the input
        cfg_data   = 16'd0;
        cfg_enable = 1'b1;
        s_tvalid   = 1'b1;
        s_tdata    = DW'(999);
        repeat (4) begin
            @(negedge clk);
            check("zero_len_closed", s_tready, 0);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;

        // len 1, then 4 with mid-packet change to 2
        cfg_data = 16'd1;
        send(DW'(300), 1'b1, 1'b0);
        send(DW'(301), 1'b1, 1'b0);
        cfg_data = 16'd4;
        send(DW'(302), 1'b1, 1'b0);
        send(DW'(310), 1'b0, 1'b0);
        cfg_data = 16'd2;
        send(DW'(311), 1'b0, 1'b0);
        send(DW'(312), 1'b0, 1'b0);
        send(DW'(313), 1'b1, 1'b0);
        send(DW'(320), 1'b0, 1'b0);
        cfg_enable = 1'b0;
        send(DW'(321), 1'b1, 1'b0);
        s_tvalid = 1'b0;
        wait_drain();

        // reset mid-packet, len 8
        cfg_data   = 16'd8;
        cfg_enable = 1'b1;
        send(DW'(400), 1'b0, 1'b0);
        send(DW'(401), 1'b0, 1'b0);
        send(DW'(402), 1'b0, 1'b0);
        s_tvalid = 1'b0;
        areset   = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_tvalid", m_tvalid, 0);
        check("midrst_tlast", m_tlast, 0);
        check("midrst_tdata", m_tdata, 0);
        check("midrst_s_tready", s_tready, 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        areset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) cfg_enable = 1'b0;
            send(DW'(500 + i), i == 7, 1'b0);
        end
        s_tvalid = 1'b0;
        wait_drain();
        @(negedge clk);
        check("final_idle", s_tready, 0);

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
